// File: rtl/pattern_scan_ctrl.sv
// Round-robin arbiter for two frame requesters. The granted frame is shifted out MSB first
// through an overlapping "1101" detector, and the match count is returned with a ready/valid handshake.
module pattern_scan_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_A,
  input  logic              REQ_B,
  input  logic [DATA_W-1:0] DATA_A,
  input  logic [DATA_W-1:0] DATA_B,
  output logic              GNT_A,
  output logic              GNT_B,
  output logic              SER_OUT,
  output logic              SER_VLD,
  output logic              DET,
  output logic              RES_VLD,
  output logic [3:0]        RES_CNT,
  output logic              RES_ID,
  input  logic              RES_RDY
);

  localparam int unsigned IdxW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [2:0] {DetS0, DetS1, DetS2, DetS3, DetS4} det_e;

  state_e            state_q;
  det_e              det_q;
  det_e              det_nxt;
  logic [DATA_W-1:0] sreg_q;
  logic [IdxW-1:0]   idx_q;
  logic [3:0]        cnt_q;
  logic              owner_q;
  logic              prio_b_q;
  logic              gnt_a_q;
  logic              gnt_b_q;
  logic              pick_b;

  // B wins when alone, or on a tie when A was served last.
  assign pick_b = REQ_B & (~REQ_A | prio_b_q);

  always_comb begin
    det_nxt = DetS0;
    unique case (det_q)
      DetS0:   det_nxt = sreg_q[DATA_W-1] ? DetS1 : DetS0;
      DetS1:   det_nxt = sreg_q[DATA_W-1] ? DetS2 : DetS0;
      DetS2:   det_nxt = sreg_q[DATA_W-1] ? DetS2 : DetS3;
      DetS3:   det_nxt = sreg_q[DATA_W-1] ? DetS4 : DetS0;
      DetS4:   det_nxt = sreg_q[DATA_W-1] ? DetS2 : DetS0;
      default: det_nxt = DetS0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      det_q    <= DetS0;
      sreg_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      prio_b_q <= 1'b0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
    end else begin
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (REQ_A || REQ_B) begin
            gnt_a_q  <= ~pick_b;
            gnt_b_q  <= pick_b;
            owner_q  <= pick_b;
            prio_b_q <= ~pick_b;
            sreg_q   <= pick_b ? DATA_B : DATA_A;
            idx_q    <= '0;
            cnt_q    <= '0;
            det_q    <= DetS0;
            state_q  <= StShift;
          end
        end
        StShift: begin
          det_q <= det_nxt;
          if (det_nxt == DetS4 && cnt_q != 4'hf) cnt_q <= cnt_q + 4'd1;
          sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
          idx_q  <= idx_q + 1'b1;
          if (idx_q == IdxW'(DATA_W - 1)) state_q <= StDone;
        end
        StDone: begin
          // Detector holds through DONE so a final-bit match stays visible on DET.
          if (RES_RDY) begin
            state_q <= StIdle;
            det_q   <= DetS0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign GNT_A   = gnt_a_q;
  assign GNT_B   = gnt_b_q;
  assign SER_VLD = (state_q == StShift);
  assign SER_OUT = (state_q == StShift) & sreg_q[DATA_W-1];
  assign DET     = (det_q == DetS4);
  assign RES_VLD = (state_q == StDone);
  assign RES_CNT = cnt_q;
  assign RES_ID  = owner_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: expected results are queued when a frame is issued
// and compared against RES_CNT/RES_ID when the result handshake comes round.
module tb_pattern_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_A, REQ_B, RES_RDY;
  logic [7:0] DATA_A, DATA_B;
  logic       GNT_A, GNT_B, SER_OUT, SER_VLD, DET, RES_VLD, RES_ID;
  logic [3:0] RES_CNT;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       id;
    logic [3:0] cnt;
  } exp_t;
  exp_t sb[$];

  pattern_scan_ctrl #(.DATA_W(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ_A   (REQ_A),
    .REQ_B   (REQ_B),
    .DATA_A  (DATA_A),
    .DATA_B  (DATA_B),
    .GNT_A   (GNT_A),
    .GNT_B   (GNT_B),
    .SER_OUT (SER_OUT),
    .SER_VLD (SER_VLD),
    .DET     (DET),
    .RES_VLD (RES_VLD),
    .RES_CNT (RES_CNT),
    .RES_ID  (RES_ID),
    .RES_RDY (RES_RDY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Frame bits k-3..k (MSB-first positions) form 1101.
  function automatic bit match_at(input logic [7:0] d, input int k);
    logic [3:0] w;
    w = {d[10-k], d[9-k], d[8-k], d[7-k]};
    return w == 4'b1101;
  endfunction

  function automatic logic [3:0] count_model(input logic [7:0] d);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 3; k < 8; k++) if (match_at(d, k) && c != 4'hf) c = c + 4'd1;
    return c;
  endfunction

  function automatic logic [31:0] outs_word();
    return {22'd0, GNT_A, GNT_B, SER_OUT, SER_VLD, DET, RES_VLD, RES_CNT};
  endfunction

  task automatic frame(input bit exp_id, input int rdy_delay, input bit req_b_in_done,
                       input string tag);
    logic [7:0] d;
    exp_t       e;
    bit         seen;
    d      = exp_id ? DATA_B : DATA_A;
    e.id   = exp_id;
    e.cnt  = count_model(d);
    sb.push_back(e);
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      tick();
      if (GNT_A || GNT_B) seen = 1'b1;
    end
    chk({tag, ".grant_seen"}, 32'(seen), 32'd1);
    if (!seen) begin
      void'(sb.pop_front());
      return;
    end
    chk({tag, ".grant_who"}, {30'd0, GNT_A, GNT_B}, exp_id ? 32'd1 : 32'd2);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) chk({tag, ".grant_1cyc"}, {30'd0, GNT_A, GNT_B}, 32'd0);
      chk({tag, ".ser_vld"}, 32'(SER_VLD), 32'd1);
      chk({tag, ".ser_out"}, 32'(SER_OUT), 32'(d[7-i]));
      chk({tag, ".det"}, 32'(DET), (i >= 4 && match_at(d, i - 1)) ? 32'd1 : 32'd0);
      tick();
    end
    chk({tag, ".res_vld"}, 32'(RES_VLD), 32'd1);
    chk({tag, ".ser_vld_done"}, 32'(SER_VLD), 32'd0);
    chk({tag, ".det_done"}, 32'(DET), 32'(match_at(d, 7)));
    e = sb.pop_front();
    chk({tag, ".res_id"}, 32'(RES_ID), 32'(e.id));
    chk({tag, ".res_cnt"}, 32'(RES_CNT), 32'(e.cnt));
    if (req_b_in_done) REQ_B = 1'b1;
    for (int s = 0; s < rdy_delay; s++) begin
      tick();
      chk({tag, ".hold_vld"}, 32'(RES_VLD), 32'd1);
      chk({tag, ".hold_cnt"}, 32'(RES_CNT), 32'(e.cnt));
      chk({tag, ".hold_id"}, 32'(RES_ID), 32'(e.id));
      chk({tag, ".hold_nognt"}, {30'd0, GNT_A, GNT_B}, 32'd0);
    end
    RES_RDY = 1'b1;
    tick();
    RES_RDY = 1'b0;
    chk({tag, ".released"}, 32'(RES_VLD), 32'd0);
    chk({tag, ".idle_nognt"}, {30'd0, GNT_A, GNT_B}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    RST = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0; RES_RDY = 1'b0;
    DATA_A = 8'h00; DATA_B = 8'h00;
    #1;
    chk("reset_outs", outs_word(), 32'd0);
    chk("reset_id", 32'(RES_ID), 32'd0);
    tick(); tick();
    RST = 1'b1;

    // Tie from reset with both held: A, B, A, B, each gated by the handshake.
    DATA_A = 8'b11011010; DATA_B = 8'b11111101;
    REQ_A = 1'b1; REQ_B = 1'b1;
    frame(1'b0, 2, 1'b0, "rr1");
    frame(1'b1, 2, 1'b0, "rr2");
    frame(1'b0, 0, 1'b0, "rr3");
    frame(1'b1, 0, 1'b0, "rr4");
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();

    REQ_A = 1'b1; DATA_A = 8'b11011010;
    frame(1'b0, 0, 1'b0, "a_alone");
    REQ_A = 1'b0;

    REQ_B = 1'b1; DATA_B = 8'b11111101;
    frame(1'b1, 0, 1'b0, "b_fd");
    DATA_B = 8'h00;
    frame(1'b1, 1, 1'b0, "b_zero");
    REQ_B = 1'b0;

    REQ_A = 1'b1; DATA_A = 8'b00001101;
    frame(1'b0, 0, 1'b0, "seq1");
    DATA_A = 8'b01000000;
    frame(1'b0, 0, 1'b0, "seq2");
    DATA_A = 8'b00000110;
    frame(1'b0, 0, 1'b0, "cross1");
    DATA_A = 8'b10000000;
    frame(1'b0, 0, 1'b0, "cross2");
    REQ_A = 1'b0;
    tick();

    // Stall in DONE with B waiting; B only granted after returning to IDLE.
    REQ_A = 1'b1; DATA_A = 8'b11011011; DATA_B = 8'b01101101;
    frame(1'b0, 5, 1'b1, "stall");
    REQ_A = 1'b0;
    frame(1'b1, 0, 1'b0, "after_stall");
    REQ_B = 1'b0;
    tick();

    // Reset mid-shift: outputs clear asynchronously, no result, pointer back to A-first.
    REQ_A = 1'b1; DATA_A = 8'b11011010;
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      tick();
      if (GNT_A) seen = 1'b1;
    end
    chk("rst.grant_seen", 32'(seen), 32'd1);
    REQ_A = 1'b0;
    repeat (4) tick();
    chk("rst.mid_shift", 32'(SER_VLD), 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("rst.async_outs", outs_word(), 32'd0);
    chk("rst.async_id", 32'(RES_ID), 32'd0);
    tick();
    RST = 1'b1;
    for (int s = 0; s < 10; s++) begin
      tick();
      chk("rst.no_result", outs_word(), 32'd0);
    end
    REQ_A = 1'b1; REQ_B = 1'b1; DATA_A = 8'b11011011; DATA_B = 8'b11010000;
    frame(1'b0, 0, 1'b0, "post_rst_tie");
    REQ_A = 1'b0;
    frame(1'b1, 0, 1'b0, "post_rst_b");
    REQ_B = 1'b0;
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
